// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRA/ROR sequencer: at most 3 bit positions per cycle on a 16-bit operand.
// Latency: result valid 1+ceil(amt/3) cycles after accept (1 for amt==0 or reserved op).
// Backpressure: result held in DONE until rsp_ready; req_ready only in IDLE; flush aborts.
module shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [3:0]  req_amt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] work;
    logic [15:0] work_shifted;
    logic [3:0]  remaining;
    logic [3:0]  rem_nxt;
    logic [1:0]  op;
    logic [1:0]  step;
    logic        accept;

    // Step is clamped to what is left, so the counter can never wrap.
    always_comb begin
        step    = (remaining > 4'd3) ? 2'd3 : remaining[1:0];
        rem_nxt = remaining - {2'b00, step};
    end

    always_comb begin
        work_shifted = work;
        case (op)
            OP_SLL:  work_shifted = work << step;
            OP_SRA:  work_shifted = 16'($signed(work) >>> step);
            OP_ROR: begin
                case (step)
                    2'd1:    work_shifted = {work[0],   work[15:1]};
                    2'd2:    work_shifted = {work[1:0], work[15:2]};
                    2'd3:    work_shifted = {work[2:0], work[15:3]};
                    default: work_shifted = work;
                endcase
            end
            default: work_shifted = work;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        rsp_valid = (state == DONE);
        busy      = (state == SHIFT) || (state == DONE);
        rsp_data  = work;
        accept    = req_valid && req_ready && !flush;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_amt == 4'd0 || req_op == OP_RSV)
                        state_nxt = DONE;
                    else
                        state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (rem_nxt == 4'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= 16'h0000;
            remaining <= 4'd0;
            op        <= OP_SLL;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work      <= req_data;
                remaining <= req_amt;
                op        <= req_op;
            end else if (state == SHIFT && !flush) begin
                work      <= work_shifted;
                remaining <= rem_nxt;
            end
        end
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift/rotate sequencer for the ALU shift path. It accepts one 16-bit operand, an operation (SLL, SRA, ROR) and a 4-bit amount over a valid/ready handshake. It then applies the shift in steps of at most 3 bit positions per cycle, which matches the 2-bit-select rotate stage used in the datapath. The result is returned over a second valid/ready handshake, and the block sits between decode/execute and writeback.

## Interface
- No parameters; data width fixed at 16, amount width fixed at 4.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; synchronous abort of any in-flight operation
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  2  00 SLL, 01 SRA, 10 ROR, 11 reserved
- req_data  in  16  operand
- req_amt  in  4  shift amount 0..15
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  result
- busy  out  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. Reset and flush force IDLE. rsp_data resets to 0x0000 and both registers clear.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) captures op, operand into the work register and amt into a 4-bit remaining counter.
  - If amt==0 or op==11, next state is DONE. Op 11 returns the operand unchanged.
  - Otherwise next state is SHIFT.
- SHIFT: each cycle sets step = min(remaining, 3) and applies it to the work register. remaining -= step.
  - Transition to DONE on the edge where remaining reaches 0.
- Step semantics:
  - SLL: logical left, zero fill.
  - SRA: arithmetic right, fill with bit 15 of the current work register.
  - ROR: rotate right, bits leaving bit 0 re-enter at bit 15.
- DONE: rsp_valid=1 and rsp_data = work register. These hold stable until rsp_ready=1, then the next state is IDLE.
- No request is accepted in SHIFT or DONE (req_ready=0). Back-to-back requests therefore have at least one IDLE cycle between them.
- The result equals a single-shot shift by amt: SLL by n = data<<n, SRA = $signed(data)>>>n, ROR = rotate right by n (mod 16).

## Timing
- Reset values: req_ready=0 during the rst cycle, then 1 (state IDLE). rsp_valid=0, busy=0, rsp_data=0x0000.
- Latency: a request is accepted at edge E0. rsp_valid is first high in cycle 1+ceil(amt/3) after the accept cycle.
  - amt=0 or op=11: 1.
  - amt 1–3: 2.
  - amt 4–6: 3.
  - amt 13–15: 6.
- The response completes on the edge where rsp_valid & rsp_ready. req_ready returns high on the next cycle.
- Boundary behaviour:
  - flush takes priority over every handshake in the same cycle. A request presented with flush high is not accepted. A pending result is dropped, and rsp_valid is low on the next cycle.
  - rst has priority over flush.
  - rst asserted mid-SHIFT returns the block to IDLE with all outputs at reset values on the next cycle.
  - Inputs req_op/req_data/req_amt are sampled only on the accept edge; later changes are ignored.
  - The remaining counter never underflows because the step is clamped to remaining.

## Test plan
- SLL 0x0001 by 15 → rsp_data 0x8000, rsp_valid 6 cycles after accept. SLL 0xFFFF by 4 → 0xFFF0, latency 3.
- SRA 0x8000 by 15 → 0xFFFF. SRA 0x7FF0 by 4 → 0x07FF. ROR 0x1234 by 4 → 0x4123, latency 3. ROR 0x8001 by 1 → 0xC000, latency 2.
- amt=0 with SLL 0xA5A5 → 0xA5A5 at latency 1. op=11 with amt=9 on 0x1234 → 0x1234 at latency 1.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE → rsp_data stable, req_ready=0, and a req_valid pulse is ignored. rsp_ready=1 → IDLE next cycle.
- flush during the 2nd SHIFT cycle of ROR by 12 → IDLE next cycle, no rsp_valid ever. The next request SLL 0x0003 by 2 → 0x000C.
- rst asserted mid-SHIFT → all outputs at reset values next cycle.
- Randomized check: 1000 random op/data/amt values with random rsp_ready, compared against the single-shot reference formulas; the latency formula is checked on every transaction.
